axi_decerr_slave: RTL and testbench



---
 rtl/axi_decerr_slave.sv | 160 ++++++++++++++++
 tb/tb_axi_decerr_slave.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_decerr_slave.sv
// AXI4 default slave: answers every unmapped transaction with DECERR,
// keeping a saturating error counter and the last faulting address.
module axi_decerr_slave #(
    parameter int unsigned IdWidth   = 5,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned AddrWidth = 64,
    parameter logic [63:0] RespData  = 64'hDEAD_BEEF_DEAD_BEEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 aw_valid_i,
    output logic                 aw_ready_o,
    input  logic [IdWidth-1:0]   aw_id_i,
    input  logic [AddrWidth-1:0] aw_addr_i,
    input  logic                 w_valid_i,
    output logic                 w_ready_o,
    input  logic                 w_last_i,
    output logic                 b_valid_o,
    input  logic                 b_ready_i,
    output logic [IdWidth-1:0]   b_id_o,
    output logic [1:0]           b_resp_o,
    input  logic                 ar_valid_i,
    output logic                 ar_ready_o,
    input  logic [IdWidth-1:0]   ar_id_i,
    input  logic [AddrWidth-1:0] ar_addr_i,
    input  logic [7:0]           ar_len_i,
    output logic                 r_valid_o,
    input  logic                 r_ready_i,
    output logic [IdWidth-1:0]   r_id_o,
    output logic [DataWidth-1:0] r_data_o,
    output logic [1:0]           r_resp_o,
    output logic                 r_last_o,
    output logic [31:0]          err_count_o,
    output logic [AddrWidth-1:0] err_addr_o
);

    localparam int unsigned CntWidth = 32;
    localparam int unsigned LenWidth = 8;
    localparam logic [1:0]  DecErr   = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    w_state_e              w_state_q, w_state_d;
    r_state_e              r_state_q, r_state_d;
    logic [IdWidth-1:0]    b_id_q, b_id_d;
    logic [IdWidth-1:0]    r_id_q, r_id_d;
    logic [LenWidth-1:0]   beat_cnt_q, beat_cnt_d;
    logic [CntWidth-1:0]   err_count_q, err_count_d;
    logic [AddrWidth-1:0]  err_addr_q, err_addr_d;
    logic                  aw_hs, ar_hs;
    logic [CntWidth:0]     count_sum;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_state_q   <= W_IDLE;
            r_state_q   <= R_IDLE;
            b_id_q      <= '0;
            r_id_q      <= '0;
            beat_cnt_q  <= '0;
            err_count_q <= '0;
            err_addr_q  <= '0;
        end else begin
            w_state_q   <= w_state_d;
            r_state_q   <= r_state_d;
            b_id_q      <= b_id_d;
            r_id_q      <= r_id_d;
            beat_cnt_q  <= beat_cnt_d;
            err_count_q <= err_count_d;
            err_addr_q  <= err_addr_d;
        end
    end

    // Write side: accept AW, swallow W beats up to WLAST, then one DECERR B.
    always_comb begin
        w_state_d  = w_state_q;
        b_id_d     = b_id_q;
        aw_ready_o = 1'b0;
        w_ready_o  = 1'b0;
        b_valid_o  = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                aw_ready_o = ~rst_i;
                if (aw_valid_i) begin
                    w_state_d = W_DATA;
                    b_id_d    = aw_id_i;
                end
            end
            W_DATA: begin
                w_ready_o = ~rst_i;
                if (w_valid_i && w_last_i) begin
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                b_valid_o = ~rst_i;
                if (b_ready_i) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read side: beat counter holds beats still owed after the current one.
    always_comb begin
        r_state_d  = r_state_q;
        r_id_d     = r_id_q;
        beat_cnt_d = beat_cnt_q;
        ar_ready_o = 1'b0;
        r_valid_o  = 1'b0;
        r_last_o   = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                ar_ready_o = ~rst_i;
                if (ar_valid_i) begin
                    r_state_d  = R_DATA;
                    r_id_d     = ar_id_i;
                    beat_cnt_d = ar_len_i;
                end
            end
            R_DATA: begin
                r_valid_o = ~rst_i;
                r_last_o  = (beat_cnt_q == '0);
                if (r_ready_i) begin
                    if (beat_cnt_q == '0) begin
                        r_state_d = R_IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q - LenWidth'(1);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    assign aw_hs = aw_valid_i & aw_ready_o;
    assign ar_hs = ar_valid_i & ar_ready_o;

    // Statistics: saturating request count; AR address wins a same-cycle tie.
    always_comb begin
        count_sum   = (CntWidth+1)'(err_count_q) + (CntWidth+1)'(aw_hs) + (CntWidth+1)'(ar_hs);
        err_count_d = count_sum[CntWidth] ? '1 : count_sum[CntWidth-1:0];
        err_addr_d  = err_addr_q;
        if (ar_hs) begin
            err_addr_d = ar_addr_i;
        end else if (aw_hs) begin
            err_addr_d = aw_addr_i;
        end
    end

    assign b_id_o      = b_id_q;
    assign b_resp_o    = DecErr;
    assign r_id_o      = r_id_q;
    assign r_data_o    = DataWidth'(RespData);
    assign r_resp_o    = DecErr;
    assign err_count_o = err_count_q;
    assign err_addr_o  = err_addr_q;

endmodule

// File: tb/tb_axi_decerr_slave.sv
// Randomised and directed bench for axi_decerr_slave against a
// transaction-level model of the DECERR responder.
module tb_axi_decerr_slave;

    localparam logic [63:0] RESP = 64'hDEAD_BEEF_DEAD_BEEF;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        aw_valid_i = 1'b0, w_valid_i = 1'b0, w_last_i = 1'b0, b_ready_i = 1'b0;
    logic        ar_valid_i = 1'b0, r_ready_i = 1'b0;
    logic [4:0]  aw_id_i = '0, ar_id_i = '0;
    logic [63:0] aw_addr_i = '0, ar_addr_i = '0;
    logic [7:0]  ar_len_i = '0;
    logic        aw_ready_o, w_ready_o, b_valid_o, ar_ready_o, r_valid_o, r_last_o;
    logic [4:0]  b_id_o, r_id_o;
    logic [1:0]  b_resp_o, r_resp_o;
    logic [63:0] r_data_o, err_addr_o;
    logic [31:0] err_count_o;

    axi_decerr_slave dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i), .aw_addr_i(aw_addr_i),
        .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_last_i(w_last_i),
        .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o), .b_resp_o(b_resp_o),
        .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id_i), .ar_addr_i(ar_addr_i),
        .ar_len_i(ar_len_i),
        .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_id_o(r_id_o), .r_data_o(r_data_o),
        .r_resp_o(r_resp_o), .r_last_o(r_last_o),
        .err_count_o(err_count_o), .err_addr_o(err_addr_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Transaction-level model: write progress, beats still owed, statistics.
    bit              m_wait_aw, m_wait_w, m_owe_b;
    logic [4:0]      m_wid, m_rid;
    int              m_rd_left;
    longint unsigned m_cnt;
    logic [63:0]     m_addr;

    int r_hs_seen = 0, r_last_seen = 0, r_last_idx = 0, b_hs_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wait_aw = 1'b1; m_wait_w = 1'b0; m_owe_b = 1'b0;
        m_wid = '0; m_rid = '0; m_rd_left = 0; m_cnt = 0; m_addr = '0;
    endtask

    task automatic model_edge();
        bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
        if (rst_i) begin
            model_reset();
            return;
        end
        aw_hs = aw_valid_i && m_wait_aw;
        w_hs  = w_valid_i && m_wait_w;
        b_hs  = b_ready_i && m_owe_b;
        ar_hs = ar_valid_i && (m_rd_left == 0);
        r_hs  = r_ready_i && (m_rd_left > 0);
        if (aw_hs) begin
            m_wait_aw = 1'b0; m_wait_w = 1'b1; m_wid = aw_id_i;
        end else if (w_hs && w_last_i) begin
            m_wait_w = 1'b0; m_owe_b = 1'b1;
        end else if (b_hs) begin
            m_owe_b = 1'b0; m_wait_aw = 1'b1;
        end
        if (ar_hs) begin
            m_rd_left = int'(ar_len_i) + 1; m_rid = ar_id_i;
        end else if (r_hs) begin
            m_rd_left--;
        end
        m_cnt = m_cnt + (aw_hs ? 1 : 0) + (ar_hs ? 1 : 0);
        if (m_cnt > 64'hFFFF_FFFF) m_cnt = 64'hFFFF_FFFF;
        if (ar_hs) m_addr = ar_addr_i;
        else if (aw_hs) m_addr = aw_addr_i;
    endtask

    task automatic compare();
        bit live;
        live = !rst_i;
        chk("aw_ready", 64'(aw_ready_o), 64'(live && m_wait_aw));
        chk("w_ready",  64'(w_ready_o),  64'(live && m_wait_w));
        chk("b_valid",  64'(b_valid_o),  64'(live && m_owe_b));
        chk("ar_ready", 64'(ar_ready_o), 64'(live && m_rd_left == 0));
        chk("r_valid",  64'(r_valid_o),  64'(live && m_rd_left > 0));
        if (live && m_owe_b) begin
            chk("b_id",   64'(b_id_o),   64'(m_wid));
            chk("b_resp", 64'(b_resp_o), 64'(2'b11));
        end
        if (live && m_rd_left > 0) begin
            chk("r_id",   64'(r_id_o),   64'(m_rid));
            chk("r_data", r_data_o,      RESP);
            chk("r_resp", 64'(r_resp_o), 64'(2'b11));
            chk("r_last", 64'(r_last_o), 64'(m_rd_left == 1));
        end
        chk("err_count", 64'(err_count_o), m_cnt);
        chk("err_addr",  err_addr_o,       m_addr);
    endtask

    // One clock: tally handshakes visible now, advance model at the edge, compare.
    task automatic step();
        if (r_valid_o && r_ready_i && !rst_i) begin
            r_hs_seen++;
            if (r_last_o) begin
                r_last_seen++;
                r_last_idx = r_hs_seen;
            end
        end
        if (b_valid_o && b_ready_i && !rst_i) b_hs_seen++;
        @(posedge clk_i);
        model_edge();
        @(negedge clk_i);
        compare();
    endtask

    task automatic idle_inputs();
        aw_valid_i = 1'b0; w_valid_i = 1'b0; w_last_i = 1'b0;
        ar_valid_i = 1'b0; b_ready_i = 1'b0; r_ready_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        idle_inputs();
        b_ready_i = 1'b1; r_ready_i = 1'b1; w_valid_i = 1'b1; w_last_i = 1'b1;
        n = 0;
        while (!(m_wait_aw && m_rd_left == 0) && n < 600) begin
            step();
            n++;
        end
        chk("drain_bound", 64'(m_wait_aw && m_rd_left == 0), 64'd1);
        idle_inputs();
        step();
    endtask

    int base_hs, base_last, base_b, n;

    initial begin
        model_reset();
        @(negedge clk_i);
        step();
        step();
        chk("reset_count", 64'(err_count_o), 64'd0);
        rst_i = 1'b0;
        #1;
        chk("post_reset_aw_ready", 64'(aw_ready_o), 64'd1);
        chk("post_reset_ar_ready", 64'(ar_ready_o), 64'd1);
        @(negedge clk_i);

        // Single-beat write.
        aw_valid_i = 1'b1; aw_id_i = 5'h13; aw_addr_i = 64'h5000_0000;
        step();
        aw_valid_i = 1'b0; w_valid_i = 1'b1; w_last_i = 1'b1; b_ready_i = 1'b1;
        step();
        chk("t1_b_valid", 64'(b_valid_o), 64'd1);
        chk("t1_b_id",    64'(b_id_o),    64'h13);
        chk("t1_b_resp",  64'(b_resp_o),  64'd3);
        w_valid_i = 1'b0;
        step();
        chk("t1_count", 64'(err_count_o), 64'd1);
        chk("t1_addr",  err_addr_o,       64'h5000_0000);
        drain();

        // len=3 read with ready held high.
        r_ready_i = 1'b1; ar_valid_i = 1'b1; ar_id_i = 5'h07; ar_len_i = 8'd3; ar_addr_i = 64'h9000;
        step();
        ar_valid_i = 1'b0;
        base_hs = r_hs_seen; base_last = r_last_seen;
        for (int i = 0; i < 4; i++) begin
            chk("t2_ar_ready_busy", 64'(ar_ready_o), 64'd0);
            step();
        end
        chk("t2_beats",     64'(r_hs_seen - base_hs),     64'd4);
        chk("t2_lasts",     64'(r_last_seen - base_last), 64'd1);
        chk("t2_last_idx",  64'(r_last_idx - base_hs),    64'd4);
        chk("t2_ar_ready",  64'(ar_ready_o),              64'd1);
        drain();

        // len=255 read with random back-pressure.
        ar_valid_i = 1'b1; ar_id_i = 5'h1A; ar_len_i = 8'd255; ar_addr_i = 64'hC000;
        step();
        ar_valid_i = 1'b0;
        base_hs = r_hs_seen; base_last = r_last_seen;
        n = 0;
        while (m_rd_left > 0 && n < 3000) begin
            r_ready_i = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        chk("t3_bound",    64'(m_rd_left),               64'd0);
        chk("t3_beats",    64'(r_hs_seen - base_hs),     64'd256);
        chk("t3_lasts",    64'(r_last_seen - base_last), 64'd1);
        chk("t3_last_idx", 64'(r_last_idx - base_hs),    64'd256);
        drain();

        // Same-cycle AW and AR.
        aw_valid_i = 1'b1; aw_addr_i = 64'hA; aw_id_i = 5'h02;
        ar_valid_i = 1'b1; ar_addr_i = 64'hB; ar_id_i = 5'h04; ar_len_i = 8'd1;
        step();
        chk("t4_count", 64'(err_count_o), 64'd5);
        chk("t4_addr",  err_addr_o,       64'hB);
        drain();

        // W beats presented before AW, then a 4-beat write.
        w_valid_i = 1'b1; w_last_i = 1'b0; b_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_w_ready_early", 64'(w_ready_o), 64'd0);
        end
        aw_valid_i = 1'b1; aw_id_i = 5'h0C; aw_addr_i = 64'h7777;
        base_b = b_hs_seen;
        step();
        aw_valid_i = 1'b0;
        chk("t5_w_ready_after_aw", 64'(w_ready_o), 64'd1);
        for (int i = 0; i < 4; i++) begin
            w_last_i = (i == 3);
            step();
        end
        w_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("t5_b_count", 64'(b_hs_seen - base_b), 64'd1);
        chk("t5_count",   64'(err_count_o),        64'd6);
        drain();

        // Reset during beat 2 of a len=7 read.
        r_ready_i = 1'b1; ar_valid_i = 1'b1; ar_id_i = 5'h03; ar_len_i = 8'd7; ar_addr_i = 64'hD000;
        step();
        ar_valid_i = 1'b0;
        base_hs = r_hs_seen;
        step();
        rst_i = 1'b1;
        step();
        chk("t6_r_valid_in_reset", 64'(r_valid_o), 64'd0);
        rst_i = 1'b0;
        #1;
        chk("t6_r_valid_after",  64'(r_valid_o),   64'd0);
        chk("t6_ar_ready_after", 64'(ar_ready_o),  64'd1);
        chk("t6_aw_ready_after", 64'(aw_ready_o),  64'd1);
        chk("t6_count_cleared",  64'(err_count_o), 64'd0);
        @(negedge clk_i);
        for (int i = 0; i < 4; i++) step();
        chk("t6_beats", 64'(r_hs_seen - base_hs), 64'd1);
        drain();

        // Counter saturation from a preloaded value.
        force dut.err_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.err_count_q;
        m_cnt = 64'hFFFF_FFFE;
        @(negedge clk_i);
        aw_valid_i = 1'b1; aw_addr_i = 64'h11; ar_valid_i = 1'b1; ar_addr_i = 64'h22; ar_len_i = 8'd0;
        step();
        drain();
        ar_valid_i = 1'b1; ar_addr_i = 64'h33; ar_len_i = 8'd0;
        step();
        drain();
        chk("t7_saturated", 64'(err_count_o), 64'hFFFF_FFFF);
        chk("t7_addr",      err_addr_o,       64'h33);

        // Random traffic with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            aw_valid_i = ($urandom_range(0, 3) == 0);
            aw_id_i    = 5'($urandom);
            aw_addr_i  = {32'($urandom), 32'($urandom)};
            w_valid_i  = 1'($urandom_range(0, 1));
            w_last_i   = ($urandom_range(0, 2) == 0);
            b_ready_i  = 1'($urandom_range(0, 1));
            ar_valid_i = ($urandom_range(0, 3) == 0);
            ar_id_i    = 5'($urandom);
            ar_addr_i  = {32'($urandom), 32'($urandom)};
            ar_len_i   = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            r_ready_i  = 1'($urandom_range(0, 1));
            rst_i      = ($urandom_range(0, 299) == 0);
            step();
        end
        rst_i = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
